seq_tx: RTL and testbench

- Serial frame transmitter; the transmit end of the single-bit serial link whose receive side is the "1001" sequence detector.
- Accepts a parallel payload word through a valid/ready handshake.
- Emits on one serial line, one bit per clock: a fixed start marker (1001), then the payload MSB-first, then an optional parity bit.
- Sits in front of the detector FSM, both as stimulus source and as the link's real transmitter.

---
 rtl/seq_pkg.sv | 22 ++
 rtl/seq_shift.sv | 48 ++++
 rtl/seq_tx.sv | 144 ++++++++++++++
 tb/tb_seq_tx.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the "1001"-framed serial link.
// The transmitter, the detector and their benches all use this package.
package seq_pkg;

    // Transmitter FSM states. PAR is entered only when the parity bit is built in.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MARK = 2'd1,
        DATA = 2'd2,
        PAR  = 2'd3
    } state_t;

    // Start-of-frame marker, sent MSB-first.
    localparam logic [3:0] MARKER_DEF   = 4'b1001;
    localparam int         MARK_LEN_DEF = 4;

    // Larger of two integers, used for counter sizing.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seq_shift.sv
// Loadable MSB-first parallel-in / serial-out shift register.
// Optional parity (macro SEQ_TX_PARITY_EN): even parity of the loaded word,
// captured alongside the payload so it is ready after the last data bit.
module seq_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data_in,
`ifdef SEQ_TX_PARITY_EN
    output logic             parity,
`endif
    output logic             msb
);

    logic [WIDTH-1:0] sr_reg;

    // Load the payload on handshake, otherwise shift left with zero fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_reg <= '0;
        end else if (load) begin
            sr_reg <= data_in;
        end else if (shift) begin
            sr_reg <= sr_reg << 1;
        end
    end

    assign msb = sr_reg[WIDTH-1];

`ifdef SEQ_TX_PARITY_EN
    logic parity_reg;

    // Even parity of the whole payload, taken once at load time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_reg <= 1'b0;
        end else if (load) begin
            parity_reg <= ^data_in;
        end
    end

    assign parity = parity_reg;
`endif

endmodule

// File: rtl/seq_tx.sv
// Serial frame transmitter: marker (MSB-first), payload (MSB-first),
// then an optional even-parity bit when SEQ_TX_PARITY_EN is defined.
// The o, busy and done outputs are registered and change on the same edge
// as the state, so o carries the bit of the current state cycle.
// ready is combinational from the state register.
module seq_tx
    import seq_pkg::*;
#(
    parameter int                    WIDTH    = 8,
    parameter int                    MARK_LEN = MARK_LEN_DEF,
    parameter logic [MARK_LEN-1:0]   MARKER   = MARKER_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    output logic             o,
    output logic             busy,
    output logic             done
);

    // One counter serves both MARK and DATA; it is reloaded on every state
    // entry and each exit happens exactly at zero.
    localparam int            CW        = $clog2(max_int(MARK_LEN, WIDTH) + 1);
    localparam int            MW        = 1 << CW;
    localparam logic [CW-1:0] MARK_LAST = CW'(MARK_LEN - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
    // Marker zero-extended so it can be indexed directly by the counter.
    localparam logic [MW-1:0] MARKER_EXT = MW'(MARKER);

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next, cnt_dec;
    logic          o_reg, o_next;
    logic          busy_reg;
    logic          done_reg, done_next;
    logic          load, shift;
    logic          sr_msb;
`ifdef SEQ_TX_PARITY_EN
    logic          sr_parity;
`endif

    seq_shift #(
        .WIDTH(WIDTH)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .shift   (shift),
        .data_in (data_in),
`ifdef SEQ_TX_PARITY_EN
        .parity  (sr_parity),
`endif
        .msb     (sr_msb)
    );

    assign cnt_dec = cnt_reg - CW'(1);

    // State register, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            o_reg     <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            o_reg     <= o_next;
            busy_reg  <= (state_next != IDLE);
            done_reg  <= done_next;
        end
    end

    // Next-state decision; MARK and DATA leave on terminal count.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (valid)          state_next = MARK;
            MARK: if (cnt_reg == '0)  state_next = DATA;
`ifdef SEQ_TX_PARITY_EN
            DATA: if (cnt_reg == '0)  state_next = PAR;
            PAR:                      state_next = IDLE;
`else
            DATA: if (cnt_reg == '0)  state_next = IDLE;
`endif
            default:                  state_next = IDLE;
        endcase
    end

    // Per-state outputs: bit to drive next, counter reload and shifter control.
    always_comb begin
        cnt_next  = cnt_reg;
        o_next    = 1'b0;
        done_next = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (valid) begin
                    load     = 1'b1;
                    cnt_next = MARK_LAST;
                    o_next   = MARKER_EXT[MARK_LAST];
                end
            end
            MARK: begin
                if (cnt_reg == '0) begin
                    cnt_next = DATA_LAST;
                    o_next   = sr_msb;
                    shift    = 1'b1;
                end else begin
                    cnt_next = cnt_dec;
                    o_next   = MARKER_EXT[cnt_dec];
                end
            end
            DATA: begin
                if (cnt_reg == '0) begin
                    cnt_next  = '0;
`ifdef SEQ_TX_PARITY_EN
                    o_next    = sr_parity;
`else
                    done_next = 1'b1;
`endif
                end else begin
                    cnt_next = cnt_dec;
                    o_next   = sr_msb;
                    shift    = 1'b1;
                end
            end
            default: begin
                // PAR: last bit already on the line, frame completes here.
                cnt_next  = '0;
                done_next = 1'b1;
            end
        endcase
    end

    assign ready = (state_reg == IDLE) && !rst;
    assign o     = o_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;

endmodule

// File: tb/tb_seq_tx.sv
// Randomized self-checking bench for seq_tx.
// The reference frame is built from the link rules: marker bits, payload
// bits MSB-first, then the even parity bit when SEQ_TX_PARITY_EN is defined.
module tb_seq_tx;
    import seq_pkg::*;

    localparam int WIDTH  = 8;
    localparam int N_RAND = 20;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] data_in = '0;
    logic             valid = 1'b0;
    logic             ready, o, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    bit exp_q[$];

    seq_tx #(
        .WIDTH    (WIDTH),
        .MARK_LEN (MARK_LEN_DEF),
        .MARKER   (MARKER_DEF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .valid   (valid),
        .ready   (ready),
        .o       (o),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference frame: marker MSB-first, payload MSB-first, optional parity.
    task automatic build_frame(input logic [WIDTH-1:0] d);
        logic [3:0] mk;
        mk = MARKER_DEF;
        exp_q.delete();
        for (int i = MARK_LEN_DEF - 1; i >= 0; i--) exp_q.push_back(mk[i]);
        for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef SEQ_TX_PARITY_EN
        exp_q.push_back(^d);
`endif
    endtask

    // Called at a negedge in an IDLE cycle with valid/data_in already set.
    // Checks every frame bit, then the done cycle; returns at that negedge.
    task automatic run_frame(input int f, input logic [WIDTH-1:0] d);
        build_frame(d);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            check($sformatf("f%0d d=%02h bit%0d o", f, d, k), 32'(o), 32'(exp_q[k]));
            check($sformatf("f%0d bit%0d busy", f, k), 32'(busy), 32'd1);
            check($sformatf("f%0d bit%0d ready", f, k), 32'(ready), 32'd0);
            check($sformatf("f%0d bit%0d done", f, k), 32'(done), 32'd0);
            // Noise on the inputs while busy must not disturb the frame.
            valid   = 1'($urandom);
            data_in = WIDTH'($urandom);
        end
        @(negedge clk);
        check($sformatf("f%0d end done", f), 32'(done), 32'd1);
        check($sformatf("f%0d end o", f), 32'(o), 32'd0);
        check($sformatf("f%0d end ready", f), 32'(ready), 32'd1);
        check($sformatf("f%0d end busy", f), 32'(busy), 32'd0);
        $display("[TB] frame %0d data=%02h bits=%0d checked", f, d, exp_q.size());
    endtask

    logic [WIDTH-1:0] frames[$];
    logic [WIDTH-1:0] d_mid;

    initial begin
        frames.push_back(8'hA5);
        frames.push_back(8'h07);
        frames.push_back(8'hFF);
        frames.push_back(8'h00);
        frames.push_back(8'h99);
        for (int i = 0; i < N_RAND; i++) frames.push_back(WIDTH'($urandom));

        // Reset held: everything clear, ready gated by rst.
        #1;
        check("rst o", 32'(o), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst ready", 32'(ready), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-rst ready", 32'(ready), 32'd1);
        @(negedge clk);
        check("idle o", 32'(o), 32'd0);
        check("idle done", 32'(done), 32'd0);

        // Frames with random gaps; FF -> 00 is forced back-to-back.
        valid   = 1'b1;
        data_in = frames[0];
        for (int f = 0; f < frames.size(); f++) begin
            run_frame(f, frames[f]);
            if (f + 1 < frames.size()) begin
                if (f == 2 || $urandom_range(1) == 1) begin
                    valid   = 1'b1;
                    data_in = frames[f + 1];
                end else begin
                    valid = 1'b0;
                    for (int g = 0; g < int'($urandom_range(3, 1)); g++) begin
                        @(negedge clk);
                        check($sformatf("gap%0d o", f), 32'(o), 32'd0);
                        check($sformatf("gap%0d done", f), 32'(done), 32'd0);
                        check($sformatf("gap%0d ready", f), 32'(ready), 32'd1);
                    end
                    valid   = 1'b1;
                    data_in = frames[f + 1];
                end
            end
        end

        // Reset between edges during data bit 3: outputs clear immediately.
        valid = 1'b0;
        @(negedge clk);
        d_mid   = WIDTH'($urandom);
        valid   = 1'b1;
        data_in = d_mid;
        build_frame(d_mid);
        for (int k = 0; k <= MARK_LEN_DEF + 3; k++) begin
            @(negedge clk);
            valid = 1'b0;
            check($sformatf("mid bit%0d o", k), 32'(o), 32'(exp_q[k]));
        end
        #1 rst = 1'b1;
        #1;
        check("mid-rst o", 32'(o), 32'd0);
        check("mid-rst busy", 32'(busy), 32'd0);
        check("mid-rst done", 32'(done), 32'd0);
        check("mid-rst ready", 32'(ready), 32'd0);
        $display("[TB] async reset during data bit 3 checked");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel ready", 32'(ready), 32'd1);
        @(negedge clk);
        check("rel done", 32'(done), 32'd0);
        check("rel busy", 32'(busy), 32'd0);
        check("rel o", 32'(o), 32'd0);

        // The next frame after release must be intact.
        valid   = 1'b1;
        data_in = 8'h5A;
        run_frame(frames.size(), 8'h5A);
        valid = 1'b0;
        @(negedge clk);
        check("final done", 32'(done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
